// File: rtl/if_fetch.sv
// Instruction fetch: one outstanding imem transaction feeding a DEPTH-entry buffer to decode.
// Latency: word visible on id_valid_o the cycle after rvalid; pc_stall_o holds the PC while busy/full/flushing.
module if_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    output logic        pc_stall_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       mem_pc_q   [DEPTH];
    logic [31:0]       mem_inst_q [DEPTH];

    logic not_full;
    logic push;
    logic pop;

    assign not_full    = count_q < DEPTH_C;
    assign push        = (state_q == WAIT) && imem_rvalid_i && !flush_i;
    assign pop         = id_valid_o && id_ready_i && !flush_i;

    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = addr_q;
    assign pc_stall_o  = !((state_q == IDLE) && not_full && !flush_i);

    assign id_valid_o  = (count_q != '0);
    assign id_pc_o     = id_valid_o ? mem_pc_q[rd_ptr_q]   : 32'h0;
    assign id_inst_o   = id_valid_o ? mem_inst_q[rd_ptr_q] : 32'h0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (ce_i && !flush_i && not_full) begin
                    addr_d  = pc_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    state_d = flush_i ? DROP : WAIT;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = IDLE;
                end else if (flush_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // A further flush just keeps draining; only the granted word's rvalid ends it.
                if (imem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked to 0 while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= addr_q;
            mem_inst_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs driven at the falling edge, outputs checked 1ns later.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        pc_stall_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int checks;
    int failures;

    if_fetch #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .pc_stall_o   (pc_stall_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: accept a at the next edge, grant after gdelay cycles, rvalid one cycle later.
    // Returns at the falling edge where the pushed entry is visible.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int gdelay);
        @(negedge clk); pc_i = a; ce_i = 1'b1;
        @(negedge clk); ce_i = 1'b0;
        repeat (gdelay) @(negedge clk);
        imem_gnt_i = 1'b1;
        @(negedge clk); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = d;
        @(negedge clk); imem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; pc_i = 32'h0; ce_i = 1'b0; flush_i = 1'b0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; id_ready_i = 1'b0;
        #3;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr_o); end
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid_o); end
        checks++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin failures++; $display("FAIL reset_id pc=%h inst=%h exp=0/0", id_pc_o, id_inst_o); end
        checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", pc_stall_o); end
        ce_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_held_req got=%b exp=0", imem_req_o); end
        ce_i = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_fetch;
        @(negedge clk); pc_i = 32'h0; ce_i = 1'b1; #1;
        checks++; if (pc_stall_o !== 1'b0) begin failures++; $display("FAIL fetch_accept_stall got=%b exp=0", pc_stall_o); end
        @(negedge clk); ce_i = 1'b0; imem_gnt_i = 1'b1; #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL fetch_req req=%b addr=%h exp=1/0", imem_req_o, imem_addr_o); end
        checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("FAIL fetch_req_stall got=%b exp=1", pc_stall_o); end
        @(negedge clk); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013; #1;
        checks++; if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0) begin failures++; $display("FAIL fetch_wait req=%b valid=%b exp=0/0", imem_req_o, id_valid_o); end
        @(negedge clk); imem_rvalid_i = 1'b0; #1;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0000_0013) begin
            failures++; $display("FAIL fetch_out valid=%b pc=%h inst=%h exp=1/0/00000013", id_valid_o, id_pc_o, id_inst_o); end
        id_ready_i = 1'b1;
        @(negedge clk); id_ready_i = 1'b0; #1;
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL fetch_pop valid=%b exp=0", id_valid_o); end
    endtask

    task automatic test_backpressure;
        do_fetch(32'h0, 32'hA000_0000, 0);
        do_fetch(32'h4, 32'hB000_0004, 0);
        pc_i = 32'h8; ce_i = 1'b1; #1;
        checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("FAIL bp_full_stall got=%b exp=1", pc_stall_o); end
        checks++; if (dut.count_q !== 2'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", dut.count_q); end
        @(negedge clk); #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL bp_no_req got=%b exp=0", imem_req_o); end
        checks++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'hA000_0000) begin failures++; $display("FAIL bp_head pc=%h inst=%h exp=0/a0000000", id_pc_o, id_inst_o); end
        id_ready_i = 1'b1;
        @(negedge clk); id_ready_i = 1'b0; #1;
        checks++; if (id_pc_o !== 32'h4 || pc_stall_o !== 1'b0) begin failures++; $display("FAIL bp_after_pop pc=%h stall=%b exp=4/0", id_pc_o, pc_stall_o); end
        @(negedge clk); ce_i = 1'b0; imem_gnt_i = 1'b1; #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin failures++; $display("FAIL bp_next_req req=%b addr=%h exp=1/8", imem_req_o, imem_addr_o); end
        @(negedge clk); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_0008;
        @(negedge clk); imem_rvalid_i = 1'b0; id_ready_i = 1'b1; #1;
        checks++; if (id_pc_o !== 32'h4 || id_inst_o !== 32'hB000_0004) begin failures++; $display("FAIL bp_drain0 pc=%h inst=%h exp=4/b0000004", id_pc_o, id_inst_o); end
        @(negedge clk); #1;
        checks++; if (id_pc_o !== 32'h8 || id_inst_o !== 32'hC000_0008) begin failures++; $display("FAIL bp_drain1 pc=%h inst=%h exp=8/c0000008", id_pc_o, id_inst_o); end
        @(negedge clk); id_ready_i = 1'b0; #1;
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty valid=%b exp=0", id_valid_o); end
    endtask

    task automatic test_gnt_delay;
        @(negedge clk); pc_i = 32'h10; ce_i = 1'b1;
        @(negedge clk); ce_i = 1'b0; pc_i = 32'hFFFF_FFF0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin
                failures++; $display("FAIL gnt_hold%0d req=%b addr=%h exp=1/10", i, imem_req_o, imem_addr_o); end
            @(negedge clk);
        end
        imem_gnt_i = 1'b1; #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10) begin failures++; $display("FAIL gnt_final req=%b addr=%h exp=1/10", imem_req_o, imem_addr_o); end
        @(negedge clk); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hD000_0010; #1;
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL gnt_dropped req=%b exp=0", imem_req_o); end
        @(negedge clk); imem_rvalid_i = 1'b0; #1;
        checks++; if (dut.count_q !== 2'd1 || id_inst_o !== 32'hD000_0010 || id_pc_o !== 32'h10) begin
            failures++; $display("FAIL gnt_one_push count=%0d pc=%h inst=%h exp=1/10/d0000010", dut.count_q, id_pc_o, id_inst_o); end
        id_ready_i = 1'b1;
        @(negedge clk); id_ready_i = 1'b0;
    endtask

    task automatic test_flush;
        // Flush in WAIT, stale rvalid two cycles later.
        @(negedge clk); pc_i = 32'h20; ce_i = 1'b1;
        @(negedge clk); ce_i = 1'b0; imem_gnt_i = 1'b1;
        @(negedge clk); imem_gnt_i = 1'b0; flush_i = 1'b1; #1;
        checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("FAIL flw_stall0 got=%b exp=1", pc_stall_o); end
        @(negedge clk); flush_i = 1'b0; pc_i = 32'h100; ce_i = 1'b1; #1;
        checks++; if (pc_stall_o !== 1'b1 || id_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            failures++; $display("FAIL flw_drop stall=%b valid=%b req=%b exp=1/0/0", pc_stall_o, id_valid_o, imem_req_o); end
        @(negedge clk); imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0; #1;
        checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("FAIL flw_stall_rvalid got=%b exp=1", pc_stall_o); end
        @(negedge clk); imem_rvalid_i = 1'b0; #1;
        checks++; if (id_valid_o !== 1'b0 || pc_stall_o !== 1'b0) begin
            failures++; $display("FAIL flw_discard valid=%b stall=%b exp=0/0", id_valid_o, pc_stall_o); end
        @(negedge clk); ce_i = 1'b0; imem_gnt_i = 1'b1; #1;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin failures++; $display("FAIL flw_refetch req=%b addr=%h exp=1/100", imem_req_o, imem_addr_o); end
        @(negedge clk); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hE000_0100;
        @(negedge clk); imem_rvalid_i = 1'b0; #1;
        checks++; if (id_pc_o !== 32'h100 || id_inst_o !== 32'hE000_0100) begin failures++; $display("FAIL flw_new pc=%h inst=%h exp=100/e0000100", id_pc_o, id_inst_o); end
        // Flush in IDLE with an entry queued and a pop offered: buffer cleared, no request.
        flush_i = 1'b1; id_ready_i = 1'b1; ce_i = 1'b1; pc_i = 32'h200; #1;
        checks++; if (pc_stall_o !== 1'b1) begin failures++; $display("FAIL fli_stall got=%b exp=1", pc_stall_o); end
        @(negedge clk); flush_i = 1'b0; id_ready_i = 1'b0; ce_i = 1'b0; #1;
        checks++; if (id_valid_o !== 1'b0 || imem_req_o !== 1'b0 || dut.count_q !== 2'd0) begin
            failures++; $display("FAIL fli_clear valid=%b req=%b count=%0d exp=0/0/0", id_valid_o, imem_req_o, dut.count_q); end
        // Flush in REQ without grant: request drops, back to IDLE.
        @(negedge clk); pc_i = 32'h300; ce_i = 1'b1;
        @(negedge clk); ce_i = 1'b0; flush_i = 1'b1; #1;
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL flr_req got=%b exp=1", imem_req_o); end
        @(negedge clk); flush_i = 1'b0; #1;
        checks++; if (imem_req_o !== 1'b0 || pc_stall_o !== 1'b0) begin failures++; $display("FAIL flr_idle req=%b stall=%b exp=0/0", imem_req_o, pc_stall_o); end
    endtask

    task automatic test_back_to_back;
        do_fetch(32'h40, 32'hF000_0040, 0);
        @(negedge clk); pc_i = 32'h44; ce_i = 1'b1;
        @(negedge clk); ce_i = 1'b0; imem_gnt_i = 1'b1;
        @(negedge clk); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hF000_0044; id_ready_i = 1'b1; #1;
        checks++; if (id_pc_o !== 32'h40) begin failures++; $display("FAIL b2b_head_before pc=%h exp=40", id_pc_o); end
        @(negedge clk); imem_rvalid_i = 1'b0; id_ready_i = 1'b0; #1;
        checks++; if (dut.count_q !== 2'd1 || id_pc_o !== 32'h44 || id_inst_o !== 32'hF000_0044) begin
            failures++; $display("FAIL b2b_after count=%0d pc=%h inst=%h exp=1/44/f0000044", dut.count_q, id_pc_o, id_inst_o); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); pc_i = 32'h80; ce_i = 1'b1;
        @(negedge clk); ce_i = 1'b0; #1;
        checks++; if (imem_req_o !== 1'b1 || id_valid_o !== 1'b1) begin failures++; $display("FAIL rmid_pre req=%b valid=%b exp=1/1", imem_req_o, id_valid_o); end
        #1; rst = 1'b0; #1;
        checks++; if (imem_req_o !== 1'b0 || id_valid_o !== 1'b0 || imem_addr_o !== 32'h0 || id_inst_o !== 32'h0) begin
            failures++; $display("FAIL rmid_async req=%b valid=%b addr=%h inst=%h exp=0/0/0/0", imem_req_o, id_valid_o, imem_addr_o, id_inst_o); end
        @(negedge clk); rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fetch();
        test_backpressure();
        test_gnt_delay();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the fetch-buffer entry count; legal values are powers of two, at least 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous and active-low.
REQ-004 pc_i  input  32  SHALL carry the fetch address from the PC register.
REQ-005 ce_i  input  1  SHALL mark pc_i valid when high.
REQ-006 pc_stall_o  output  1  SHALL tell the PC register to hold pc_i when high.
REQ-007 flush_i  input  1  SHALL, when high, request a redirect and discard all fetched or in-flight instructions.
REQ-008 imem_req_o  output  1  SHALL be the instruction-memory request strobe.
REQ-009 imem_addr_o  output  32  SHALL be the instruction-memory word address.
REQ-010 imem_gnt_i  input  1  SHALL be the memory's request acceptance.
REQ-011 imem_rvalid_i  input  1  SHALL be the memory's read-data-valid strobe.
REQ-012 imem_rdata_i  input  32  SHALL be the instruction word.
REQ-013 id_valid_o  output  1  SHALL mark id_pc_o/id_inst_o valid for decode.
REQ-014 id_ready_i  input  1  SHALL indicate decode accepts the current entry.
REQ-015 id_pc_o  output  32  SHALL be the head-entry PC.
REQ-016 id_inst_o  output  32  SHALL be the head-entry instruction.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and DROP, with at most one memory transaction outstanding.
REQ-018 IDLE: if ce_i=1, flush_i=0 and count<DEPTH, the block SHALL latch pc_i into imem_addr_o, assert imem_req_o and go to REQ; otherwise it stays in IDLE.
REQ-019 pc_stall_o SHALL be combinational: 0 only when state=IDLE, count<DEPTH and flush_i=0; otherwise 1.
REQ-020 REQ: imem_req_o=1 and imem_addr_o SHALL hold stable until imem_gnt_i=1 is sampled, then the block SHALL deassert the request and go to WAIT.
REQ-021 WAIT: on imem_rvalid_i=1, the block SHALL push {imem_addr_o, imem_rdata_i} into the FIFO and go to IDLE.
REQ-022 imem_rvalid_i SHALL be ignored in IDLE and REQ; memory guarantees rvalid at least 1 cycle after gnt.
REQ-023 The FIFO SHALL have DEPTH entries with pointers wrapping modulo DEPTH and count width log2(DEPTH)+1.
REQ-024 The FIFO SHALL pop on id_valid_o&&id_ready_i; a simultaneous push and pop SHALL leave count unchanged.
REQ-025 Push SHALL never occur when full: a request is issued only while count<DEPTH, and pops only reduce count.
REQ-026 id_valid_o SHALL equal (count!=0); id_pc_o/id_inst_o SHALL show the head entry, or 0 when empty.
REQ-027 Flush in IDLE: the FIFO SHALL be cleared and no request issued that cycle.
REQ-028 Flush in REQ with imem_gnt_i=0: the request SHALL drop next cycle and the state go to IDLE.
REQ-029 Flush in REQ with imem_gnt_i=1: the state SHALL go to DROP.
REQ-030 Flush in WAIT with imem_rvalid_i=0: the state SHALL go to DROP.
REQ-031 Flush in WAIT with imem_rvalid_i=1: the data SHALL be discarded and the state go to IDLE.
REQ-032 Flush in DROP: the state SHALL remain DROP.
REQ-033 DROP: the block SHALL wait for imem_rvalid_i=1, discard the data, go to IDLE, issue no request and keep pc_stall_o=1.
REQ-034 Flush SHALL take priority over push and pop; the pop handshake in a flush cycle is void, and id_valid_o=0 the next cycle.
REQ-035 Latency: an instruction SHALL appear on id_valid_o the cycle after its rvalid; with gnt in the request cycle and rvalid one cycle later, it appears 3 cycles after pc acceptance.

Reset
REQ-036 On rst=0, the block SHALL asynchronously set state IDLE, count 0, FIFO pointers 0 and imem_req_o=0.
REQ-037 On rst=0, imem_addr_o, id_pc_o and id_inst_o SHALL be 0 and id_valid_o=0.
REQ-038 A reset mid-transaction SHALL abandon the transaction; memory is reset by the same rst.
REQ-039 The first request SHALL be issued no earlier than the first rising clk edge after rst returns to 1.

Verification
REQ-040 Fetch: pc_i=0x0, ce_i=1, gnt same cycle, rvalid+1 with rdata=0x00000013 -> id_valid_o=1, id_pc_o=0x0, id_inst_o=0x00000013.
REQ-041 Backpressure: id_ready_i=0; fetches at 0x0 and 0x4 complete -> count=2, pc_stall_o=1, no imem_req_o; one pop -> next fetch at 0x8 issues.
REQ-042 Gnt delay: gnt withheld 3 cycles -> imem_req_o=1 and imem_addr_o=0x10 stable throughout; exactly one push.
REQ-043 Flush in WAIT with rvalid 2 cycles later -> stale word not pushed, id_valid_o=0, pc_stall_o=1 until rvalid, then next pc_i=0x100 fetched.
REQ-044 Simultaneous: count=1, push and pop in same cycle -> count stays 1, head advances to new entry.
REQ-045 Reset mid-REQ: rst=0 asynchronously -> imem_req_o=0 and id_valid_o=0 before next clk edge.
